// File: rtl/mem_miss_arbiter.sv
// Merges I$ and D$ miss streams into one main-memory port, strictly oldest-first,
// with a single outstanding memory transaction and a tagged response back to the core.
module mem_miss_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned THR_W  = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              icache_req_valid,
  output logic              icache_req_ready,
  input  logic [ADDR_W-1:0] icache_req_addr,
  input  logic [THR_W-1:0]  icache_req_thr,
  input  logic              dcache_req_valid,
  output logic              dcache_req_ready,
  input  logic [ADDR_W-1:0] dcache_req_addr,
  input  logic              dcache_req_store,
  input  logic [LINE_W-1:0] dcache_req_data,
  input  logic [THR_W-1:0]  dcache_req_thr,
  output logic              mm_req_valid,
  input  logic              mm_req_ready,
  output logic [ADDR_W-1:0] mm_req_addr,
  output logic              mm_req_store,
  output logic [LINE_W-1:0] mm_req_data,
  input  logic              mm_rsp_valid,
  input  logic [LINE_W-1:0] mm_rsp_data,
  input  logic              mm_rsp_error,
  output logic              rsp_valid_miss,
  output logic              rsp_cache_id,
  output logic [THR_W-1:0]  rsp_thread_id,
  output logic [LINE_W-1:0] rsp_data_miss,
  output logic              rsp_bus_error
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned OQW = $clog2(2 * DEPTH);
  localparam int unsigned IW  = ADDR_W + THR_W;
  localparam int unsigned DW  = ADDR_W + 1 + LINE_W + THR_W;
  localparam logic [PW:0]    PtrOne   = 1;
  localparam logic [OQW:0]   OqOne    = 1;
  localparam logic [OQW-1:0] OqIdxOne = 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
  state_e state_q, state_d;

  logic [IW-1:0]    i_mem [DEPTH];
  logic [DW-1:0]    d_mem [DEPTH];
  logic [PW:0]      i_wptr_q, i_rptr_q, d_wptr_q, d_rptr_q;
  logic [2*DEPTH-1:0] oq_mem_q;
  logic [OQW:0]     oq_wptr_q, oq_rptr_q;

  logic i_full, i_empty, d_full, d_empty, oq_empty, oq_head;
  logic i_push, d_push, pop_i, pop_d;
  logic [OQW-1:0] oq_widx, oq_widx1;

  logic [ADDR_W-1:0] hold_addr_q;
  logic              hold_store_q, hold_cid_q;
  logic [LINE_W-1:0] hold_data_q;
  logic [THR_W-1:0]  hold_thr_q;

  logic              rsp_cid_q, rsp_err_q;
  logic [THR_W-1:0]  rsp_thr_q;
  logic [LINE_W-1:0] rsp_data_q;

  assign i_empty = (i_wptr_q == i_rptr_q);
  assign d_empty = (d_wptr_q == d_rptr_q);
  assign i_full  = (i_wptr_q[PW] != i_rptr_q[PW]) && (i_wptr_q[PW-1:0] == i_rptr_q[PW-1:0]);
  assign d_full  = (d_wptr_q[PW] != d_rptr_q[PW]) && (d_wptr_q[PW-1:0] == d_rptr_q[PW-1:0]);
  // Order queue holds one id per buffered request, so it can never overflow.
  assign oq_empty = (oq_wptr_q == oq_rptr_q);
  assign oq_head  = oq_mem_q[oq_rptr_q[OQW-1:0]];
  assign oq_widx  = oq_wptr_q[OQW-1:0];
  assign oq_widx1 = oq_widx + OqIdxOne;

  assign icache_req_ready = !i_full;
  assign dcache_req_ready = !d_full;
  assign i_push = icache_req_valid && !i_full;
  assign d_push = dcache_req_valid && !d_full;

  always_comb begin
    state_d = state_q;
    pop_i   = 1'b0;
    pop_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!oq_empty) begin
          if (oq_head && !d_empty) begin
            pop_d   = 1'b1;
            state_d = StIssue;
          end else if (!oq_head && !i_empty) begin
            pop_i   = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: if (mm_req_ready) state_d = StWait;
      StWait:  if (mm_rsp_valid) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_push) i_mem[i_wptr_q[PW-1:0]] <= {icache_req_addr, icache_req_thr};
    if (d_push) begin
      d_mem[d_wptr_q[PW-1:0]] <= {dcache_req_addr, dcache_req_store, dcache_req_data,
                                  dcache_req_thr};
    end
    // D$ takes the older slot on a same-cycle tie.
    if (d_push) oq_mem_q[oq_widx] <= 1'b1;
    if (i_push) oq_mem_q[d_push ? oq_widx1 : oq_widx] <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      i_wptr_q     <= '0;
      i_rptr_q     <= '0;
      d_wptr_q     <= '0;
      d_rptr_q     <= '0;
      oq_wptr_q    <= '0;
      oq_rptr_q    <= '0;
      hold_addr_q  <= '0;
      hold_store_q <= 1'b0;
      hold_data_q  <= '0;
      hold_thr_q   <= '0;
      hold_cid_q   <= 1'b0;
      rsp_cid_q    <= 1'b0;
      rsp_thr_q    <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (i_push) i_wptr_q <= i_wptr_q + PtrOne;
      if (d_push) d_wptr_q <= d_wptr_q + PtrOne;
      oq_wptr_q <= oq_wptr_q + (i_push ? OqOne : '0) + (d_push ? OqOne : '0);
      if (pop_i || pop_d) oq_rptr_q <= oq_rptr_q + OqOne;
      if (pop_i) begin
        i_rptr_q     <= i_rptr_q + PtrOne;
        {hold_addr_q, hold_thr_q} <= i_mem[i_rptr_q[PW-1:0]];
        hold_store_q <= 1'b0;
        hold_data_q  <= '0;
        hold_cid_q   <= 1'b0;
      end
      if (pop_d) begin
        d_rptr_q   <= d_rptr_q + PtrOne;
        {hold_addr_q, hold_store_q, hold_data_q, hold_thr_q} <= d_mem[d_rptr_q[PW-1:0]];
        hold_cid_q <= 1'b1;
      end
      if (state_q == StWait && mm_rsp_valid) begin
        rsp_cid_q  <= hold_cid_q;
        rsp_thr_q  <= hold_thr_q;
        rsp_data_q <= mm_rsp_data;
        rsp_err_q  <= mm_rsp_error;
      end
    end
  end

  assign mm_req_valid   = (state_q == StIssue);
  assign mm_req_addr    = hold_addr_q;
  assign mm_req_store   = hold_store_q;
  assign mm_req_data    = hold_data_q;
  assign rsp_valid_miss = (state_q == StResp);
  assign rsp_cache_id   = rsp_cid_q;
  assign rsp_thread_id  = rsp_thr_q;
  assign rsp_data_miss  = rsp_data_q;
  assign rsp_bus_error  = rsp_err_q;

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed bench for mem_miss_arbiter: latency, ordering, stalls, back-pressure, errors, reset.
module tb_mem_miss_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned THR_W  = 2;
  localparam int unsigned DEPTH  = 4;

  logic clock = 1'b0;
  logic reset;
  logic icache_req_valid, icache_req_ready;
  logic [ADDR_W-1:0] icache_req_addr;
  logic [THR_W-1:0]  icache_req_thr;
  logic dcache_req_valid, dcache_req_ready, dcache_req_store;
  logic [ADDR_W-1:0] dcache_req_addr;
  logic [LINE_W-1:0] dcache_req_data;
  logic [THR_W-1:0]  dcache_req_thr;
  logic mm_req_valid, mm_req_ready, mm_req_store;
  logic [ADDR_W-1:0] mm_req_addr;
  logic [LINE_W-1:0] mm_req_data;
  logic mm_rsp_valid, mm_rsp_error;
  logic [LINE_W-1:0] mm_rsp_data;
  logic rsp_valid_miss, rsp_cache_id, rsp_bus_error;
  logic [THR_W-1:0]  rsp_thread_id;
  logic [LINE_W-1:0] rsp_data_miss;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_miss_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .THR_W(THR_W), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_thr(icache_req_thr),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_req_addr(dcache_req_addr), .dcache_req_store(dcache_req_store),
    .dcache_req_data(dcache_req_data), .dcache_req_thr(dcache_req_thr),
    .mm_req_valid(mm_req_valid), .mm_req_ready(mm_req_ready),
    .mm_req_addr(mm_req_addr), .mm_req_store(mm_req_store), .mm_req_data(mm_req_data),
    .mm_rsp_valid(mm_rsp_valid), .mm_rsp_data(mm_rsp_data), .mm_rsp_error(mm_rsp_error),
    .rsp_valid_miss(rsp_valid_miss), .rsp_cache_id(rsp_cache_id),
    .rsp_thread_id(rsp_thread_id), .rsp_data_miss(rsp_data_miss),
    .rsp_bus_error(rsp_bus_error)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expects mm_req_ready=1; waits for the issue, acks it and returns one response.
  task automatic serve(input string tag, input logic [ADDR_W-1:0] a, input logic st,
                       input logic [LINE_W-1:0] d, input logic [LINE_W-1:0] rd,
                       input logic err, input logic cid, input logic [THR_W-1:0] thr);
    int n = 0;
    while (!mm_req_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, ".req_valid"}, LINE_W'(mm_req_valid), 1);
    check({tag, ".req_addr"}, LINE_W'(mm_req_addr), LINE_W'(a));
    check({tag, ".req_store"}, LINE_W'(mm_req_store), LINE_W'(st));
    if (st) check({tag, ".req_data"}, mm_req_data, d);
    step();
    check({tag, ".wait_valid"}, LINE_W'(mm_req_valid), 0);
    mm_rsp_valid = 1'b1;
    mm_rsp_data  = rd;
    mm_rsp_error = err;
    step();
    mm_rsp_valid = 1'b0;
    mm_rsp_error = 1'b0;
    check({tag, ".rsp_valid"}, LINE_W'(rsp_valid_miss), 1);
    check({tag, ".rsp_cid"}, LINE_W'(rsp_cache_id), LINE_W'(cid));
    check({tag, ".rsp_thr"}, LINE_W'(rsp_thread_id), LINE_W'(thr));
    check({tag, ".rsp_data"}, rsp_data_miss, rd);
    check({tag, ".rsp_err"}, LINE_W'(rsp_bus_error), LINE_W'(err));
    step();
    check({tag, ".rsp_pulse"}, LINE_W'(rsp_valid_miss), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] a5;
    int n;
    a5 = {16{8'hA5}};
    reset = 1'b0;
    icache_req_valid = 0; icache_req_addr = '0; icache_req_thr = '0;
    dcache_req_valid = 0; dcache_req_addr = '0; dcache_req_store = 0;
    dcache_req_data = '0; dcache_req_thr = '0;
    mm_req_ready = 1; mm_rsp_valid = 0; mm_rsp_data = '0; mm_rsp_error = 0;
    repeat (3) step();
    check("rst.mm_valid", LINE_W'(mm_req_valid), 0);
    check("rst.mm_addr", LINE_W'(mm_req_addr), 0);
    check("rst.rsp_valid", LINE_W'(rsp_valid_miss), 0);
    check("rst.rsp_data", rsp_data_miss, 0);
    reset = 1'b1;
    step();
    check("rst.iready", LINE_W'(icache_req_ready), 1);
    check("rst.dready", LINE_W'(dcache_req_ready), 1);

    // Single I$ load: issue in cycle 2, response 4 cycles later.
    icache_req_valid = 1; icache_req_addr = 32'h40; icache_req_thr = 2'd1;
    step();
    icache_req_valid = 0;
    check("t1.c1_valid", LINE_W'(mm_req_valid), 0);
    step();
    check("t1.c2_valid", LINE_W'(mm_req_valid), 1);
    check("t1.c2_addr", LINE_W'(mm_req_addr), 32'h40);
    check("t1.c2_store", LINE_W'(mm_req_store), 0);
    step();
    check("t1.c3_valid", LINE_W'(mm_req_valid), 0);
    step(); step(); step();
    mm_rsp_valid = 1; mm_rsp_data = a5;
    check("t1.c6_rsp", LINE_W'(rsp_valid_miss), 0);
    step();
    mm_rsp_valid = 0;
    check("t1.c7_rsp", LINE_W'(rsp_valid_miss), 1);
    check("t1.cid", LINE_W'(rsp_cache_id), 0);
    check("t1.thr", LINE_W'(rsp_thread_id), 1);
    check("t1.data", rsp_data_miss, a5);
    step();
    check("t1.pulse", LINE_W'(rsp_valid_miss), 0);
    check("t1.hold_data", rsp_data_miss, a5);

    // Same-cycle tie: D$ first.
    icache_req_valid = 1; icache_req_addr = 32'h100; icache_req_thr = 2'd2;
    dcache_req_valid = 1; dcache_req_addr = 32'h200; dcache_req_thr = 2'd3;
    dcache_req_store = 0; dcache_req_data = '0;
    step();
    icache_req_valid = 0; dcache_req_valid = 0;
    serve("t2a", 32'h200, 0, '0, 128'h1111, 0, 1, 2'd3);
    serve("t2b", 32'h100, 0, '0, 128'h2222, 0, 0, 2'd2);

    // D$ store with a 3-cycle memory stall.
    mm_req_ready = 0;
    dcache_req_valid = 1; dcache_req_addr = 32'h80; dcache_req_store = 1;
    dcache_req_data = 128'hDEAD; dcache_req_thr = 2'd0;
    step();
    dcache_req_valid = 0; dcache_req_store = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3.stall%0d_valid", i), LINE_W'(mm_req_valid), 1);
      check($sformatf("t3.stall%0d_addr", i), LINE_W'(mm_req_addr), 32'h80);
      check($sformatf("t3.stall%0d_store", i), LINE_W'(mm_req_store), 1);
      check($sformatf("t3.stall%0d_data", i), mm_req_data, 128'hDEAD);
      step();
    end
    mm_req_ready = 1;
    serve("t3", 32'h80, 1, 128'hDEAD, 128'h5, 0, 1, 2'd0);

    // Back-pressure: I$ request parks in the hold register, then four D$ loads fill the FIFO.
    mm_req_ready = 0;
    icache_req_valid = 1; icache_req_addr = 32'h300; icache_req_thr = 2'd1;
    step();
    icache_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      dcache_req_valid = 1; dcache_req_addr = 32'h1000 + 32'(i * 16);
      dcache_req_thr = 2'(i); dcache_req_data = '0;
      check($sformatf("t4.ready%0d", i), LINE_W'(dcache_req_ready), 1);
      step();
    end
    dcache_req_addr = 32'h9999; dcache_req_thr = 2'd0;
    check("t4.full0", LINE_W'(dcache_req_ready), 0);
    step();
    check("t4.full1", LINE_W'(dcache_req_ready), 0);
    dcache_req_valid = 0;
    mm_req_ready = 1;
    serve("t4i", 32'h300, 0, '0, 128'h30, 0, 0, 2'd1);
    for (int i = 0; i < 4; i++) begin
      serve($sformatf("t4d%0d", i), 32'h1000 + 32'(i * 16), 0, '0, LINE_W'(i + 7), 0, 1,
            2'(i));
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (mm_req_valid) n++;
      step();
    end
    check("t4.no_fifth", LINE_W'(n), 0);
    check("t4.ready_back", LINE_W'(dcache_req_ready), 1);

    // Bus error on a D$ load.
    dcache_req_valid = 1; dcache_req_addr = 32'hFFFF_0000; dcache_req_thr = 2'd2;
    step();
    dcache_req_valid = 0;
    serve("t5", 32'hFFFF_0000, 0, '0, 128'hBAD, 1, 1, 2'd2);

    // Reset while waiting for memory, then a stale response.
    icache_req_valid = 1; icache_req_addr = 32'h500; icache_req_thr = 2'd3;
    dcache_req_valid = 1; dcache_req_addr = 32'h600; dcache_req_thr = 2'd1;
    step();
    icache_req_valid = 0; dcache_req_valid = 0;
    n = 0;
    while (!mm_req_valid && n < 20) begin
      step();
      n++;
    end
    check("t6.issued", LINE_W'(mm_req_valid), 1);
    step();
    reset = 0;
    step(); step();
    reset = 1;
    mm_rsp_valid = 1; mm_rsp_data = 128'h77;
    step();
    mm_rsp_valid = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid_miss || mm_req_valid) n++;
      step();
    end
    check("t6.quiet", LINE_W'(n), 0);
    check("t6.iready", LINE_W'(icache_req_ready), 1);
    check("t6.dready", LINE_W'(dcache_req_ready), 1);
    check("t6.rsp_data", rsp_data_miss, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
